usb_tx_ctrl: RTL

USB full-speed transmit packet sequencer that drives the NRZI encoder stage. On a start request it serialises SYNC, PID, an optional data payload read byte-by-byte from the TX buffer, and CRC16 for data PIDs. It performs bit stuffing, generates the per-bit `enable_pts` strobe and raw bit stream, and finishes with EOP signalling through `send_EOP`.

---
 rtl/usb_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_ctrl.sv
// USB full-speed transmit packet sequencer: SYNC, PID, payload, CRC16, bit stuffing
// and EOP, emitting one raw bit per CLKS_PER_BIT clocks toward the NRZI stage.
module usb_tx_ctrl #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_size,
    input  logic [7:0] buf_data,
    output logic       buf_get,
    output logic       serial_out,
    output logic       enable_pts,
    output logic       send_EOP,
    output logic       tx_busy,
    output logic       tx_done
);

    // Handshakes: tx_start is a single-cycle request taken only in IDLE (no queueing);
    // buf_get is a single-cycle pop and buf_data is captured on the edge ending that cycle.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP1, S_EOP2, S_EOPJ, S_DONE
    } state_t;

    state_t        state_q, state_d, adv_state;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]    idx_q, idx_d, adv_idx;
    logic [2:0]    ones_q, ones_d;
    logic [15:0]   crc_q, crc_d;
    logic [3:0]    pid_q, pid_d;
    logic [6:0]    size_q, size_d;
    logic [6:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          pending_q, pending_d;
    logic          stuff_q, stuff_d;
    logic          serial_q, serial_d;
    logic          eop_q, eop_d;
    logic          pts_q, pts_d;
    logic          get_q, get_d;
    logic          adv_bit;

    logic       in_pkt;
    logic       boundary;
    logic       is_data;
    logic       pop_due;
    logic [7:0] pid_byte;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h8005 : 16'h0000);
    endfunction

    assign in_pkt   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign boundary = in_pkt && (bit_cnt_q == LAST_CNT);
    assign is_data  = (pid_q == 4'b0011) || (pid_q == 4'b1011);
    assign pid_byte = {~pid_q, pid_q};

    // Pop the next byte just after the last bit of the preceding byte starts;
    // stuffed periods repeat state/idx, so they are excluded.
    assign pop_due = pts_q && !stuff_q && (idx_q == 4'd7) &&
                     (((state_q == S_PID) && is_data && (size_q != 7'd0)) ||
                      ((state_q == S_DATA) && (byte_cnt_q < size_q)));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        crc_d      = crc_q;
        pid_d      = pid_q;
        size_d     = size_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        pending_d  = pending_q;
        stuff_d    = stuff_q;
        serial_d   = serial_q;
        eop_d      = eop_q;
        pts_d      = 1'b0;
        get_d      = pop_due;
        adv_state  = state_q;
        adv_idx    = idx_q;
        adv_bit    = 1'b1;

        if (in_pkt) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + CW'(1);
        end

        if (get_q) begin
            shift_d    = buf_data;
            byte_cnt_d = byte_cnt_q + 7'd1;
            pending_d  = 1'b1;
        end

        // Next data bit in sequence, from the field/index of the last data bit sent
        case (state_q)
            S_SYNC: begin
                if (idx_q == 4'd7) begin
                    adv_state = S_PID;
                    adv_idx   = 4'd0;
                    adv_bit   = pid_byte[0];
                end else begin
                    adv_idx = idx_q + 4'd1;
                    adv_bit = SYNC_BYTE[idx_q[2:0] + 3'd1];
                end
            end
            S_PID: begin
                if (idx_q == 4'd7) begin
                    adv_idx = 4'd0;
                    if (is_data && (size_q != 7'd0)) begin
                        adv_state = S_DATA;
                        adv_bit   = shift_q[0];
                    end else if (is_data) begin
                        adv_state = S_CRC;
                        adv_bit   = ~crc_q[15];
                    end else begin
                        adv_state = S_EOP1;
                    end
                end else begin
                    adv_idx = idx_q + 4'd1;
                    adv_bit = pid_byte[idx_q[2:0] + 3'd1];
                end
            end
            S_DATA: begin
                if (idx_q == 4'd7) begin
                    adv_idx = 4'd0;
                    if (pending_q) begin
                        adv_state = S_DATA;
                        adv_bit   = shift_q[0];
                    end else begin
                        adv_state = S_CRC;
                        adv_bit   = ~crc_q[15];
                    end
                end else begin
                    adv_idx = idx_q + 4'd1;
                    adv_bit = shift_q[idx_q[2:0] + 3'd1];
                end
            end
            S_CRC: begin
                if (idx_q == 4'd15) begin
                    adv_state = S_EOP1;
                    adv_idx   = 4'd0;
                end else begin
                    adv_idx = idx_q + 4'd1;
                    adv_bit = ~crc_q[4'd14 - idx_q];
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d    = S_SYNC;
                    bit_cnt_d  = '0;
                    idx_d      = 4'd0;
                    ones_d     = 3'd0;
                    crc_d      = 16'hFFFF;
                    pid_d      = tx_pid;
                    size_d     = tx_size;
                    byte_cnt_d = 7'd0;
                    pending_d  = 1'b0;
                    stuff_d    = 1'b0;
                    serial_d   = SYNC_BYTE[0];
                    eop_d      = 1'b0;
                    pts_d      = 1'b1;
                end
            end
            S_SYNC, S_PID, S_DATA, S_CRC: begin
                if (boundary) begin
                    pts_d = 1'b1;
                    if (ones_q == 3'd6) begin
                        stuff_d  = 1'b1;
                        serial_d = 1'b0;
                        ones_d   = 3'd0;
                    end else begin
                        stuff_d = 1'b0;
                        state_d = adv_state;
                        idx_d   = adv_idx;
                        if (adv_state == S_EOP1) begin
                            serial_d = 1'b1;
                            eop_d    = 1'b1;
                            ones_d   = 3'd0;
                        end else begin
                            serial_d = adv_bit;
                            ones_d   = adv_bit ? ones_q + 3'd1 : 3'd0;
                        end
                        if (adv_state == S_DATA) begin
                            crc_d = crc_step(crc_q, adv_bit);
                            if (adv_idx == 4'd0) begin
                                pending_d = 1'b0;
                            end
                        end
                    end
                end
            end
            S_EOP1: begin
                if (boundary) begin
                    state_d  = S_EOP2;
                    pts_d    = 1'b1;
                    serial_d = 1'b1;
                    eop_d    = 1'b1;
                end
            end
            S_EOP2: begin
                if (boundary) begin
                    state_d  = S_EOPJ;
                    pts_d    = 1'b1;
                    serial_d = 1'b1;
                    eop_d    = 1'b0;
                end
            end
            S_EOPJ: begin
                if (boundary) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= 4'd0;
            ones_q     <= 3'd0;
            crc_q      <= 16'hFFFF;
            pid_q      <= 4'd0;
            size_q     <= 7'd0;
            byte_cnt_q <= 7'd0;
            shift_q    <= 8'd0;
            pending_q  <= 1'b0;
            stuff_q    <= 1'b0;
            serial_q   <= 1'b1;
            eop_q      <= 1'b0;
            pts_q      <= 1'b0;
            get_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            ones_q     <= ones_d;
            crc_q      <= crc_d;
            pid_q      <= pid_d;
            size_q     <= size_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            pending_q  <= pending_d;
            stuff_q    <= stuff_d;
            serial_q   <= serial_d;
            eop_q      <= eop_d;
            pts_q      <= pts_d;
            get_q      <= get_d;
        end
    end

    assign serial_out = serial_q;
    assign send_EOP   = eop_q;
    assign enable_pts = pts_q;
    assign buf_get    = get_q;
    assign tx_busy    = in_pkt;
    assign tx_done    = (state_q == S_DONE);

endmodule
